// File: rtl/athena_dip_sync.sv
// Settles live DIP/game config into a glitch-free snapshot and sequences core reset on game change.
// Latency: SETTLE_CYCLES quiet cycles to accept, RESET_CYCLES reset hold; CPU read data one cycle after strobe.
// No backpressure: CPU reads are always served; input changes simply restart settling.
package athena;
    typedef enum logic [1:0] {
        game_athena        = 2'd0,
        game_fighting_golf = 2'd1
    } game_e;
endpackage

module athena_dip_sync #(
    parameter int SETTLE_CYCLES = 1024,
    parameter int RESET_CYCLES  = 256,
    parameter bit INVERT        = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   dip_switches,
    input  athena::game_e game,
    output logic [15:0]   dip_snapshot,
    output athena::game_e game_active,
    output logic          core_reset,
    output logic          cfg_valid,
    input  logic          cpu_rd,
    input  logic          cpu_sel,
    output logic [7:0]    cpu_rd_data,
    output logic          cpu_rd_valid
);
    localparam int MAX_CYCLES = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [7:0]    RD_MASK     = INVERT ? 8'hFF : 8'h00;

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [15:0]   dip_q;
    athena::game_e game_q;
    logic          first_q;
    logic          change;
    logic          need_reset;
    logic [7:0]    rd_byte;

    // The first cycle out of reset is forced to look like a change so power-on always settles.
    assign change     = first_q || (dip_switches != dip_q) || (game != game_q);
    // A reset still pending from an aborted hold must be completed, not skipped.
    assign need_reset = (game != game_active) || !cfg_valid || core_reset;
    assign rd_byte    = (cpu_sel ? dip_snapshot[15:8] : dip_snapshot[7:0]) ^ RD_MASK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_SETTLE;
            cnt          <= '0;
            dip_q        <= '0;
            game_q       <= athena::game_athena;
            first_q      <= 1'b1;
            dip_snapshot <= '0;
            game_active  <= athena::game_athena;
            core_reset   <= 1'b1;
            cfg_valid    <= 1'b0;
            cpu_rd_data  <= '0;
            cpu_rd_valid <= 1'b0;
        end else begin
            dip_q        <= dip_switches;
            game_q       <= game;
            first_q      <= 1'b0;
            cpu_rd_valid <= cpu_rd;
            if (cpu_rd) begin
                cpu_rd_data <= rd_byte;
            end

            if (change) begin
                state <= ST_SETTLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            dip_snapshot <= dip_switches;
                            if (need_reset) begin
                                game_active <= game;
                                core_reset  <= 1'b1;
                                state       <= ST_HOLD;
                                cnt         <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            core_reset <= 1'b0;
                            cfg_valid  <= 1'b1;
                            state      <= ST_IDLE;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_IDLE: begin
                        core_reset <= 1'b0;
                    end
                    default: begin
                        state <= ST_SETTLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_athena_dip_sync.sv
// Randomized scoreboard bench for athena_dip_sync against a quiet-run/countdown reference model.
module tb_athena_dip_sync;
    localparam int S = 8;
    localparam int R = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   dip_switches = 16'h1234;
    athena::game_e game = athena::game_athena;
    logic          cpu_rd = 1'b0;
    logic          cpu_sel = 1'b0;
    logic [15:0]   dip_snapshot;
    athena::game_e game_active;
    logic          core_reset, cfg_valid, cpu_rd_valid;
    logic [7:0]    cpu_rd_data;

    athena_dip_sync #(.SETTLE_CYCLES(S), .RESET_CYCLES(R), .INVERT(1'b1)) dut (
        .clk(clk), .reset(reset), .dip_switches(dip_switches), .game(game),
        .dip_snapshot(dip_snapshot), .game_active(game_active), .core_reset(core_reset),
        .cfg_valid(cfg_valid), .cpu_rd(cpu_rd), .cpu_sel(cpu_sel),
        .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   snap;
        athena::game_e ga;
        logic          crst;
        logic          cv;
        logic          rv;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    int         checks = 0;
    int         failures = 0;

    // Reference model: "quiet" counts unchanged cycles since the last input change,
    // "hold_left" counts down remaining reset-hold cycles, "waiting" means a config is being settled.
    logic [15:0]   m_snap, m_prev_dip;
    athena::game_e m_game, m_prev_game;
    logic          m_crst, m_cv, m_rv, m_first;
    bit            waiting;
    int            quiet, hold_left;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_snap = 16'h0; m_game = athena::game_athena;
        m_crst = 1'b1;  m_cv = 1'b0; m_rv = 1'b0; m_first = 1'b1;
        waiting = 1'b1; quiet = 0; hold_left = 0;
        rd_q.delete();
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.snap = m_snap; e.ga = m_game; e.crst = m_crst; e.cv = m_cv; e.rv = m_rv;
        return e;
    endfunction

    task automatic model_edge();
        bit chg;
        if (reset) begin
            model_reset();
        end else begin
            m_rv = cpu_rd;
            if (cpu_rd) rd_q.push_back((cpu_sel ? m_snap[15:8] : m_snap[7:0]) ^ 8'hFF);
            chg = m_first || (dip_switches != m_prev_dip) || (game != m_prev_game);
            m_first = 1'b0; m_prev_dip = dip_switches; m_prev_game = game;
            if (chg) begin
                waiting = 1'b1; quiet = 0; hold_left = 0;
            end else if (waiting) begin
                quiet++;
                if (quiet == S) begin
                    waiting = 1'b0;
                    m_snap = dip_switches;
                    if (game != m_game || !m_cv || m_crst) begin
                        m_game = game; m_crst = 1'b1; hold_left = R;
                    end
                end
            end else if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) begin
                    m_crst = 1'b0; m_cv = 1'b1;
                end
            end else begin
                m_crst = 1'b0;
            end
        end
        exp_q.push_back(cur_exp());
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_edge();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dip_snapshot", dip_snapshot, e.snap);
            chk("game_active", 16'(game_active), 16'(e.ga));
            chk("core_reset", 16'(core_reset), 16'(e.crst));
            chk("cfg_valid", 16'(cfg_valid), 16'(e.cv));
            chk("cpu_rd_valid", 16'(cpu_rd_valid), 16'(e.rv));
            if (cpu_rd_valid) begin
                if (rd_q.size() == 0) chk("cpu_rd_unexpected", 16'(cpu_rd_data), 16'hFFFF);
                else                  chk("cpu_rd_data", 16'(cpu_rd_data), 16'(rd_q.pop_front()));
            end
        end
    end

    task automatic cpu_read(input logic sel);
        cpu_rd = 1'b1; cpu_sel = sel;
        tick(1);
        cpu_rd = 1'b0;
    endtask

    initial begin
        model_reset();
        m_prev_dip = 16'h0; m_prev_game = athena::game_athena;
        tick(3);
        reset = 1'b0;

        // Power-on acceptance followed by the reset hold
        tick(S + R + 4);
        chk("poweron_snapshot", dip_snapshot, 16'h1234);
        chk("poweron_cfg_valid", 16'(cfg_valid), 16'h1);
        chk("poweron_core_reset", 16'(core_reset), 16'h0);

        // DIP-only update
        dip_switches = 16'h00A5;
        tick(S + 4);
        chk("dip_only_snapshot", dip_snapshot, 16'h00A5);

        // Back-to-back CPU reads of 16'h1234
        dip_switches = 16'h1234;
        tick(S + 4);
        cpu_read(1'b0);
        cpu_read(1'b1);
        tick(2);

        // Game change
        game = athena::game_fighting_golf;
        tick(S + R + 4);
        chk("game_change_active", 16'(game_active), 16'(athena::game_fighting_golf));

        // Restarting changes every 5 cycles, then settle on 16'hFFFF
        for (int i = 0; i < 4; i++) begin
            dip_switches = 16'h1000 + 16'(i);
            tick(5);
        end
        dip_switches = 16'hFFFF;
        tick(S + 4);

        // Async reset on the second reset-hold cycle
        game = athena::game_athena;
        tick(S + 1 + 2);
        reset = 1'b1;
        #1;
        model_reset();
        void'(exp_q.pop_back());
        exp_q.push_back(cur_exp());
        chk("async_core_reset", 16'(core_reset), 16'h1);
        chk("async_cfg_valid", 16'(cfg_valid), 16'h0);
        chk("async_snapshot", dip_snapshot, 16'h0);
        tick(2);
        reset = 1'b0;
        tick(S + R + 4);
        chk("rerun_snapshot", dip_snapshot, 16'hFFFF);
        chk("rerun_cfg_valid", 16'(cfg_valid), 16'h1);

        // Randomized mix of changes, reads and quiet stretches
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0, 1: dip_switches = 16'($urandom);
                2:    game = athena::game_e'($urandom_range(0, 1));
                default: ;
            endcase
            cpu_rd  = ($urandom_range(0, 2) == 0);
            cpu_sel = 1'($urandom_range(0, 1));
            tick(1);
            cpu_rd = 1'b0;
            tick($urandom_range(0, 12));
        end

        tick(2);
        @(negedge clk);
        #1;
        chk("rd_queue_drained", 16'(rd_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
